// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects a host start pulse on the open-drain bus and
// answers with the response preamble plus a 40-bit humidity/temperature frame.
module dht11_responder #(
   parameter int unsigned US_DIV       = 100,
   parameter int unsigned START_MIN_US = 18000,
   parameter int unsigned RESP_DLY_US  = 30,
   parameter int unsigned RESP_US      = 80,
   parameter int unsigned BIT_LOW_US   = 50,
   parameter int unsigned BIT0_HIGH_US = 26,
   parameter int unsigned BIT1_HIGH_US = 70
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] rh_int,
   input  logic [7:0] rh_dec,
   input  logic [7:0] t_int,
   input  logic [7:0] t_dec,
   input  logic       csum_err,
   output logic       busy,
   output logic       frame_done,
   output logic [2:0] state_dbg,
   inout  wire        dht11_io
);

   localparam int unsigned PRE_W = $clog2(US_DIV + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HOST_LOW  = 3'd1,
      WAIT      = 3'd2,
      RESP_LOW  = 3'd3,
      RESP_HIGH = 3'd4,
      BIT_LOW   = 3'd5,
      BIT_HIGH  = 3'd6,
      END_LOW   = 3'd7
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         sync_q, sync_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [15:0]        us_q, us_d;
   logic [5:0]         bit_q, bit_d;
   logic [39:0]        shift_q, shift_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               synced, fall, tick, phase_end, drive_low;
   logic [15:0]        phase_us;
   logic [9:0]         sum10;
   logic [7:0]         csum;
   logic [39:0]        frame_w;

   // sync_q[1] is the synchronized bus, sync_q[2] its previous value for edge detection
   assign sync_d = {sync_q[1:0], dht11_io};
   assign synced = sync_q[1];
   assign fall   = sync_q[2] & ~sync_q[1];
   assign tick   = (pre_q == PRE_W'(US_DIV - 1));

   assign sum10   = 10'(rh_int) + 10'(rh_dec) + 10'(t_int) + 10'(t_dec);
   assign csum    = 8'(sum10) ^ {7'b0, csum_err};
   assign frame_w = {rh_int, rh_dec, t_int, t_dec, csum};

   always_comb begin
      phase_us = '0;
      case (state_q)
         WAIT:                phase_us = 16'(RESP_DLY_US);
         RESP_LOW, RESP_HIGH: phase_us = 16'(RESP_US);
         BIT_LOW, END_LOW:    phase_us = 16'(BIT_LOW_US);
         BIT_HIGH:            phase_us = shift_q[39] ? 16'(BIT1_HIGH_US) : 16'(BIT0_HIGH_US);
         default:             phase_us = '0;
      endcase
   end

   assign phase_end = tick && (us_q == phase_us - 16'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sync_q  <= '1;
         pre_q   <= '0;
         us_q    <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         pre_q   <= pre_d;
         us_q    <= us_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (en && fall) state_d = HOST_LOW;
         HOST_LOW:  if (synced) state_d = (us_q >= 16'(START_MIN_US)) ? WAIT : IDLE;
         WAIT:      if (phase_end) state_d = RESP_LOW;
         RESP_LOW:  if (phase_end) state_d = RESP_HIGH;
         RESP_HIGH: if (phase_end) state_d = BIT_LOW;
         BIT_LOW:   if (phase_end) state_d = BIT_HIGH;
         BIT_HIGH:  if (phase_end) state_d = (bit_q == 6'd39) ? END_LOW : BIT_LOW;
         END_LOW:   if (phase_end) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      pre_d   = pre_q;
      us_d    = us_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      // Every state entry restarts the timebase; the us count saturates instead of wrapping
      if ((state_d != state_q) || (state_q == IDLE)) begin
         pre_d = '0;
         us_d  = '0;
      end else if (tick) begin
         pre_d = '0;
         if (us_q != '1) us_d = us_q + 16'd1;
      end else begin
         pre_d = pre_q + PRE_W'(1);
      end
      case (state_q)
         HOST_LOW: if (state_d == WAIT) begin
            shift_d = frame_w;
            busy_d  = 1'b1;
         end
         RESP_HIGH: if (phase_end) bit_d = '0;
         BIT_HIGH: if (phase_end) begin
            shift_d = {shift_q[38:0], 1'b0};
            bit_d   = bit_q + 6'd1;
         end
         END_LOW: if (phase_end) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      drive_low = 1'b0;
      case (state_q)
         RESP_LOW, BIT_LOW, END_LOW: drive_low = 1'b1;
         default:                    drive_low = 1'b0;
      endcase
   end

   assign dht11_io   = drive_low ? 1'b0 : 1'bz;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign state_dbg  = state_q;

endmodule
